// File: rtl/fir_coeff_loader_if.sv
// Coefficient stream bundle between a coefficient producer and fir_coeff_loader.
interface fir_coeff_loader_if #(
  parameter int unsigned DATA_WIDTH = 24
);

  logic                  i_load_start;
  logic [DATA_WIDTH-1:0] iv_coeff;
  logic                  i_coeff_valid;
  logic                  o_coeff_ready;

  // Producer side
  modport master (
    output i_load_start,
    output iv_coeff,
    output i_coeff_valid,
    input  o_coeff_ready
  );

  // Loader side
  modport slave (
    input  i_load_start,
    input  iv_coeff,
    input  i_coeff_valid,
    output o_coeff_ready
  );

endinterface

// File: rtl/fir_coeff_loader.sv
// Loads NUM_TAPS signed coefficients into a shadow bank over a valid/ready
// stream, then swaps the whole bank into the tap-facing active bank in one edge.
module fir_coeff_loader #(
  parameter int unsigned DATA_WIDTH = 24,
  parameter int unsigned NUM_TAPS   = 16
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  fir_coeff_loader_if.slave              coeff_if,
  output logic [NUM_TAPS*DATA_WIDTH-1:0] ov_weights,
  output logic                           o_busy,
  output logic                           o_load_done,
  output logic                           o_load_err
);

  localparam int unsigned CNT_W = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_TAPS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t                state, state_nxt;
  logic [CNT_W-1:0]      count, count_nxt;
  logic [DATA_WIDTH-1:0] shadow [NUM_TAPS];
  logic                  wr_en;
  logic                  commit;
  logic                  done_nxt;
  logic                  err_nxt;
  logic                  ready_c;

  assign coeff_if.o_coeff_ready = ready_c;

  // Next-state, handshake and pulse decode
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    wr_en     = 1'b0;
    commit    = 1'b0;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    ready_c   = 1'b0;
    case (state)
      IDLE: begin
        if (coeff_if.i_load_start) begin
          state_nxt = LOAD;
          count_nxt = '0;
        end
      end
      LOAD: begin
        ready_c = !coeff_if.i_load_start;
        if (coeff_if.i_load_start) begin
          // Restart: discard progress, old shadow slots get overwritten later
          count_nxt = '0;
          err_nxt   = 1'b1;
        end else if (coeff_if.i_coeff_valid) begin
          wr_en = 1'b1;
          if (count == LAST_IDX) begin
            state_nxt = COMMIT;
          end else begin
            count_nxt = count + CNT_W'(1);
          end
        end
      end
      COMMIT: begin
        commit    = 1'b1;
        done_nxt  = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        count_nxt = '0;
      end
    endcase
  end

  // State, counter and status pulse registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= IDLE;
      count       <= '0;
      o_busy      <= 1'b0;
      o_load_done <= 1'b0;
      o_load_err  <= 1'b0;
    end else begin
      state       <= state_nxt;
      count       <= count_nxt;
      o_busy      <= (state_nxt != IDLE);
      o_load_done <= done_nxt;
      o_load_err  <= err_nxt;
    end
  end

  // Shadow bank capture, one slot per accepted word
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < NUM_TAPS; k++) begin
        shadow[k] <= '0;
      end
    end else if (wr_en) begin
      shadow[count] <= coeff_if.iv_coeff;
    end
  end

  // Active bank: changes only on commit so taps see an atomic swap
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ov_weights <= '0;
    end else if (commit) begin
      for (int k = 0; k < NUM_TAPS; k++) begin
        ov_weights[k*DATA_WIDTH +: DATA_WIDTH] <= shadow[k];
      end
    end
  end

endmodule
